// File: rtl/frac_pkg.sv
// Shared constants and state encoding for the QPEL 8x8 fractional-search sequencer.
package frac_pkg;

  localparam int unsigned FS_ROWS      = 8;
  localparam int unsigned ROW_W        = 3;
  localparam int unsigned FS_ORG_FIRST = 1;
  localparam int unsigned FS_ORG_LAST  = 6;
  localparam int unsigned MEM_RD_LAT   = 1;
  localparam int unsigned FS_RSLT_LAT  = 2;
  localparam int unsigned PIX_W        = 64;
  localparam int unsigned ORG_W        = 48;
  localparam int unsigned MV_W         = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_ISSUE = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CAPT  = 3'd5,
    ST_HOLD  = 3'd6
  } state_t;

endpackage

// File: rtl/frac_search_ctrl_if.sv
// Result handshake carrying the captured motion vector and its block index.
interface frac_search_ctrl_if
  import frac_pkg::*;
#(
  parameter int unsigned BLK_W = 7
) ();

  logic             res_valid;
  logic             res_ready;
  logic [MV_W-1:0]  res_mvx;
  logic [MV_W-1:0]  res_mvy;
  logic [BLK_W-1:0] res_blk_idx;

  modport master (output res_valid, res_mvx, res_mvy, res_blk_idx, input res_ready);
  modport slave  (input res_valid, res_mvx, res_mvy, res_blk_idx, output res_ready);

endinterface

// File: rtl/frac_search_ctrl.sv
// Sequencer feeding one cur/org 8x8 block pair to frac_search and returning its motion vector.
module frac_search_ctrl
  import frac_pkg::*;
#(
  parameter int unsigned BLK_W  = 7,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BLK_W-1:0]      blk_idx,
  output logic                  busy,
  output logic                  cur_rd_en,
  output logic [ADDR_W-1:0]     cur_addr,
  input  logic [PIX_W-1:0]      cur_rd_data,
  output logic                  org_rd_en,
  output logic [ADDR_W-1:0]     org_addr,
  input  logic [PIX_W-1:0]      org_rd_data,
  output logic                  fs_rst,
  output logic                  fs_ready,
  output logic [PIX_W-1:0]      fs_cur_pix,
  output logic [ORG_W-1:0]      fs_org_pix,
  input  logic [MV_W-1:0]       fs_mvx,
  input  logic [MV_W-1:0]       fs_mvy,
  frac_search_ctrl_if.master    res
);

  state_t           state;
  logic [ROW_W-1:0] cnt;
  logic [ROW_W-1:0] row_nxt;
  logic [BLK_W-1:0] blk_lat;
  logic             org_vld;
  logic             unused_org_bits;

  assign row_nxt = cnt + ROW_W'(1);

  // Buffer rows go straight to the datapath; org lanes stay zero until the first org row lands.
  assign fs_cur_pix      = cur_rd_data;
  assign fs_org_pix      = org_vld ? org_rd_data[55:8] : '0;
  assign unused_org_bits = ^{org_rd_data[63:56], org_rd_data[7:0]};

  // Sequencer: row counter, buffer reads, datapath control and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      blk_lat         <= '0;
      busy            <= 1'b0;
      cur_rd_en       <= 1'b0;
      cur_addr        <= '0;
      org_rd_en       <= 1'b0;
      org_addr        <= '0;
      org_vld         <= 1'b0;
      fs_rst          <= 1'b0;
      fs_ready        <= 1'b0;
      res.res_valid   <= 1'b0;
      res.res_mvx     <= '0;
      res.res_mvy     <= '0;
      res.res_blk_idx <= '0;
    end else begin
      fs_rst    <= 1'b0;
      cur_rd_en <= 1'b0;
      org_rd_en <= 1'b0;
      org_vld   <= org_rd_en;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_CLR;
            blk_lat   <= blk_idx;
            busy      <= 1'b1;
            fs_rst    <= 1'b1;
            cnt       <= '0;
            cur_rd_en <= 1'b1;
            cur_addr  <= ADDR_W'({blk_idx, ROW_W'(0)});
          end
        end
        ST_CLR: begin
          state     <= ST_ISSUE;
          cnt       <= ROW_W'(1);
          cur_rd_en <= 1'b1;
          cur_addr  <= ADDR_W'({blk_lat, ROW_W'(1)});
          fs_ready  <= 1'b1;
        end
        ST_ISSUE: begin
          if (cnt == ROW_W'(FS_ROWS - 1)) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else begin
            cnt       <= row_nxt;
            cur_rd_en <= 1'b1;
            cur_addr  <= ADDR_W'({blk_lat, row_nxt});
            // org row r-1 trails cur row r so both land together at the datapath
            if (cnt >= ROW_W'(FS_ORG_FIRST) && cnt <= ROW_W'(FS_ORG_LAST)) begin
              org_rd_en <= 1'b1;
              org_addr  <= ADDR_W'({blk_lat, cnt});
            end
          end
        end
        ST_DRAIN: begin
          if (cnt == ROW_W'(MEM_RD_LAT - 1)) begin
            state    <= ST_WAIT;
            cnt      <= '0;
            fs_ready <= 1'b0;
          end else begin
            cnt <= row_nxt;
          end
        end
        ST_WAIT: begin
          if (cnt == ROW_W'(FS_RSLT_LAT - 2)) begin
            state <= ST_CAPT;
            cnt   <= '0;
          end else begin
            cnt <= row_nxt;
          end
        end
        ST_CAPT: begin
          state           <= ST_HOLD;
          res.res_valid   <= 1'b1;
          res.res_mvx     <= fs_mvx;
          res.res_mvy     <= fs_mvy;
          res.res_blk_idx <= blk_lat;
        end
        ST_HOLD: begin
          if (res.res_ready) begin
            state         <= ST_IDLE;
            res.res_valid <= 1'b0;
            busy          <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frac_search_ctrl.sv
// Directed bench for frac_search_ctrl with row-buffer models and a scripted frac_search result.
module tb_frac_search_ctrl;

  localparam logic [63:0] CUR_TAG = 64'hCC00_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  blk_idx = '0;
  logic        busy;
  logic        cur_rd_en;
  logic [9:0]  cur_addr;
  logic [63:0] cur_rd_data = '0;
  logic        org_rd_en;
  logic [9:0]  org_addr;
  logic [63:0] org_rd_data = '0;
  logic        fs_rst;
  logic        fs_ready;
  logic [63:0] fs_cur_pix;
  logic [47:0] fs_org_pix;
  logic [2:0]  fs_mvx = '0;
  logic [2:0]  fs_mvy = '0;

  int npass  = 0;
  int nfail  = 0;
  int ntotal = 0;

  frac_search_ctrl_if #(.BLK_W(7)) res_if ();

  frac_search_ctrl #(.BLK_W(7), .ADDR_W(10)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .blk_idx     (blk_idx),
    .busy        (busy),
    .cur_rd_en   (cur_rd_en),
    .cur_addr    (cur_addr),
    .cur_rd_data (cur_rd_data),
    .org_rd_en   (org_rd_en),
    .org_addr    (org_addr),
    .org_rd_data (org_rd_data),
    .fs_rst      (fs_rst),
    .fs_ready    (fs_ready),
    .fs_cur_pix  (fs_cur_pix),
    .fs_org_pix  (fs_org_pix),
    .fs_mvx      (fs_mvx),
    .fs_mvy      (fs_mvy),
    .res         (res_if)
  );

  always #5 clk = ~clk;

  // Row buffers: one-cycle read latency, output holds when not read.
  always @(posedge clk) begin
    if (cur_rd_en) cur_rd_data <= CUR_TAG | 64'(cur_addr);
    if (org_rd_en) org_rd_data <= {8'hEE, 38'h0, org_addr, 8'h11};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, " busy"},        64'(busy), 64'(0));
    chk({tag, " cur_rd_en"},   64'(cur_rd_en), 64'(0));
    chk({tag, " org_rd_en"},   64'(org_rd_en), 64'(0));
    chk({tag, " fs_rst"},      64'(fs_rst), 64'(0));
    chk({tag, " fs_ready"},    64'(fs_ready), 64'(0));
    chk({tag, " res_valid"},   64'(res_if.res_valid), 64'(0));
    chk({tag, " res_mvx"},     64'(res_if.res_mvx), 64'(0));
    chk({tag, " res_mvy"},     64'(res_if.res_mvy), 64'(0));
    chk({tag, " res_blk_idx"}, 64'(res_if.res_blk_idx), 64'(0));
    chk({tag, " cur_addr"},    64'(cur_addr), 64'(0));
    chk({tag, " org_addr"},    64'(org_addr), 64'(0));
    chk({tag, " fs_org_pix"},  64'(fs_org_pix), 64'(0));
  endtask

  // Runs one job from IDLE (current cycle is C0) and checks every output cycle by cycle.
  task automatic do_job(input int blk, input int mvx, input int mvy, input int bp);
    int base;
    base = blk * 8;
    res_if.res_ready = (bp == 0);
    blk_idx = 7'(blk);
    start = 1'b1;
    tick();
    start = 1'b0;
    blk_idx = 7'h55;
    for (int c = 1; c <= 11; c++) begin
      chk($sformatf("busy C%0d", c),      64'(busy), 64'(1));
      chk($sformatf("fs_rst C%0d", c),    64'(fs_rst), 64'(c == 1));
      chk($sformatf("cur_rd_en C%0d", c), 64'(cur_rd_en), 64'(c <= 8));
      if (c <= 8) chk($sformatf("cur_addr C%0d", c), 64'(cur_addr), 64'(base + c - 1));
      chk($sformatf("org_rd_en C%0d", c), 64'(org_rd_en), 64'(c >= 3 && c <= 8));
      if (c >= 3 && c <= 8) chk($sformatf("org_addr C%0d", c), 64'(org_addr), 64'(base + c - 2));
      chk($sformatf("fs_ready C%0d", c),  64'(fs_ready), 64'(c >= 2 && c <= 9));
      if (c >= 2 && c <= 9)
        chk($sformatf("fs_cur_pix C%0d", c), fs_cur_pix, CUR_TAG | 64'(base + c - 2));
      if (c == 2 || c == 3) chk($sformatf("fs_org_pix C%0d", c), 64'(fs_org_pix), 64'(0));
      if (c >= 4 && c <= 9)
        chk($sformatf("fs_org_pix C%0d", c), 64'(fs_org_pix), 64'(base + c - 3));
      chk($sformatf("res_valid C%0d", c), 64'(res_if.res_valid), 64'(0));
      start = (c == 3);
      if (c == 10) begin
        fs_mvx = 3'(mvx);
        fs_mvy = 3'(mvy);
      end
      tick();
    end
    start = 1'b0;
    // C12: result presented
    chk("res_valid C12",   64'(res_if.res_valid), 64'(1));
    chk("res_mvx C12",     64'(res_if.res_mvx), 64'(mvx));
    chk("res_mvy C12",     64'(res_if.res_mvy), 64'(mvy));
    chk("res_blk_idx C12", 64'(res_if.res_blk_idx), 64'(blk));
    chk("busy C12",        64'(busy), 64'(1));
    chk("fs_ready C12",    64'(fs_ready), 64'(0));
    fs_mvx = ~3'(mvx);
    fs_mvy = ~3'(mvy);
    for (int k = 0; k < bp; k++) begin
      tick();
      chk($sformatf("bp res_valid %0d", k), 64'(res_if.res_valid), 64'(1));
      chk($sformatf("bp res_mvx %0d", k),   64'(res_if.res_mvx), 64'(mvx));
      chk($sformatf("bp res_mvy %0d", k),   64'(res_if.res_mvy), 64'(mvy));
      chk($sformatf("bp res_blk %0d", k),   64'(res_if.res_blk_idx), 64'(blk));
      chk($sformatf("bp busy %0d", k),      64'(busy), 64'(1));
      chk($sformatf("bp fs_ready %0d", k),  64'(fs_ready), 64'(0));
    end
    res_if.res_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy after handshake",      64'(busy), 64'(0));
    chk("res_valid after handshake", 64'(res_if.res_valid), 64'(0));
    chk("fs_rst after handshake",    64'(fs_rst), 64'(0));
    chk("fs_ready after handshake",  64'(fs_ready), 64'(0));
  endtask

  initial begin
    res_if.res_ready = 1'b1;
    #3;
    check_reset_vals("reset");
    tick();
    tick();
    reset = 1'b0;
    tick();
    check_reset_vals("idle");

    do_job(3, 5, 2, 0);
    // start ignored at handshake: still idle one cycle later
    tick();
    chk("no job after handshake start busy", 64'(busy), 64'(0));
    chk("no job after handshake start rst",  64'(fs_rst), 64'(0));

    do_job(10, 1, 6, 5);

    // Reset in C6 of a job
    blk_idx = 7'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("pre-reset busy C6", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    check_reset_vals("mid-job reset");
    reset = 1'b0;
    tick();
    check_reset_vals("after reset idle");

    do_job(9, 4, 3, 0);
    do_job(0, 7, 0, 0);
    do_job(127, 2, 5, 0);
    tick();
    chk("final busy",      64'(busy), 64'(0));
    chk("final res_valid", 64'(res_if.res_valid), 64'(0));

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/frac_search_ctrl.md
Name: frac_search_ctrl

Overview:
- Sequencer for the QPEL 8x8 fractional search datapath (frac_search).
- On a start request it fetches one current 8x8 block and one original 8x8 block from two row-addressed block buffers (64-bit rows).
- It clears the search datapath's SAD accumulators, then streams rows with the required cur/org skew.
- It captures mvx/mvy and presents them with a valid/ready result handshake; it sits between the integer-search block scheduler and frac_search.

Parameters:
- BLK_W, 7, width of block index; row address = {blk_idx, row[2:0]}
- ADDR_W, 10, row address width of both buffers (= BLK_W+3)

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  job request, sampled in IDLE only
- blk_idx  input  BLK_W  block to process, latched with start
- busy  output  1  high in every state except IDLE
- cur_rd_en  output  1  current-buffer read enable
- cur_addr  output  ADDR_W  current-buffer row address
- cur_rd_data  input  64  current row, valid 1 cycle after cur_rd_en
- org_rd_en  output  1  original-buffer read enable
- org_addr  output  ADDR_W  original-buffer row address
- org_rd_data  input  64  original row, valid 1 cycle after org_rd_en
- fs_rst  output  1  per-job clear to frac_search (ORed with reset one level up)
- fs_ready  output  1  to frac_search ready
- fs_cur_pix  output  64  to frac_search cur_pix
- fs_org_pix  output  48  to frac_search org_pix[55:8] = org_rd_data[55:8]
- fs_mvx, fs_mvy  input  3 each  from frac_search
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_mvx, res_mvy  output  3 each  captured vector
- res_blk_idx  output  BLK_W  block the result belongs to

Behaviour:
- Reset: state IDLE, counter 0. busy, cur_rd_en, org_rd_en, fs_rst, fs_ready, res_valid = 0. res_mvx, res_mvy, res_blk_idx, cur_addr, org_addr = 0.
- States: IDLE, CLR, ISSUE, DRAIN, WAIT, CAPT, HOLD. Cycle numbering: C0 = cycle where start=1 is sampled in IDLE.
- C0: latch blk_idx; next state CLR.
- C1 (CLR): fs_rst=1 for exactly this cycle; issue cur row 0.
- C2..C8 (ISSUE, row r=1..7): issue cur row r. For r>=2, also issue org row r-1. No org read for r<2.
- Read data is not registered again: fs_cur_pix = cur_rd_data and fs_org_pix = org_rd_data[55:8].
- fs_ready=1 exactly in C2..C9, i.e. 8 consecutive cycles with cur rows 0..7. Org rows 1..6 arrive in C4..C9 alongside cur rows 2..7.
- fs_org_pix is don't-care in C2, C3. Drive 0 there; no read is issued.
- C9 (DRAIN): last row presented; no reads.
- C10 (WAIT): fs_ready=0; frac_search is in its result state and updates mvx/mvy at the end of C10.
- C11 (CAPT): register fs_mvx, fs_mvy into res_* at the end of C11.
- C12 (HOLD): res_valid=1, so start-to-res_valid latency is 12 cycles.
  - Hold res_* stable while res_valid && !res_ready.
  - Handshake (res_valid && res_ready) deasserts res_valid next cycle and returns to IDLE.
  - res_ready already high in C12 means IDLE in C13, so minimum job period is 13 cycles.
- start outside IDLE: ignored; not queued. start in the same cycle as the HOLD handshake: ignored. It must be re-presented once busy=0.
- fs_ready is never high in IDLE, CLR, WAIT, CAPT or HOLD. This guarantees frac_search sees ready=0 between jobs.
- Addresses:
  - cur_addr = {blk_lat, r}
  - org_addr = {blk_lat, r-1}
  - Both hold their last value when the enable is low.
- Reset mid-job: immediate return to reset values. No result is produced and no partial result is retained.
- res_ready while res_valid=0: no effect.

Decomposition:
- Shared package frac_pkg:
  - state encoding constants
  - FS_ROWS=8, FS_ORG_FIRST=1, FS_ORG_LAST=6
  - MEM_RD_LAT=1, FS_RSLT_LAT=2
- No sub-module. The row counter and FSM are a single process; frac_search is instantiated beside this block by the parent, not inside it.

Test Plan:
- Single job, blk_idx=3, res_ready=1:
  - cur_addr runs 24..31 over C1..C8; org_addr runs 25..30 over C3..C8.
  - fs_ready is high C2..C9; fs_rst is high in C1 only.
  - res_valid rises in C12 with res_blk_idx=3; busy=0 in C13.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid → res_* stable, busy=1; raising res_ready → IDLE next cycle.
- Model frac_search driving fs_mvx=5, fs_mvy=2 at end of C10 → res_mvx=5, res_mvy=2. Changing fs_* after C11 leaves res_* unchanged.
- start pulses in C3 and in the HOLD handshake cycle → ignored, no second fs_rst. A start at C13 → new job with fs_rst in C14.
- Assert reset in C6 → all outputs 0 next cycle, state IDLE. A following start runs a full 12-cycle job.
- Back-to-back jobs blk_idx=0 then 127 (res_ready=1) → fs_ready low for at least 4 cycles between bursts; second job's addresses are 1016..1023.
